// File: rtl/sysio_arb_if.sv
// sysio_arb_if: one AXI4-Lite link (AW/W/AR/R channels, no B channel) as
// seen by the sysio arbiter.
//   master modport : drives awaddr/awvalid, wdata/wstrb/wvalid, araddr/arvalid,
//                    rready; receives awready/wready, arready, rdata/rvalid.
//   slave modport  : the mirror image.
interface sysio_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   axi_awaddr;
  logic            axi_awvalid;
  logic            axi_awready;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wvalid;
  logic            axi_wready;
  logic [AW-1:0]   axi_araddr;
  logic            axi_arvalid;
  logic            axi_arready;
  logic [DW-1:0]   axi_rdata;
  logic            axi_rvalid;
  logic            axi_rready;

  modport master (
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
           axi_araddr, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_arready, axi_rdata, axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
           axi_araddr, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_arready, axi_rdata, axi_rvalid
  );
endinterface

// File: rtl/sysio_arb.sv
// sysio_arb: two-master AXI4-Lite arbiter in front of the sysio peripheral
// slave port. Write and read channels are arbitrated independently; the
// single outstanding read is tracked so R is returned to its issuer.
//   clk : system clock (rising edge)
//   rst : asynchronous active-high reset
//   m0  : core data port   (slave modport of sysio_arb_if)
//   m1  : debug/DMA port   (slave modport of sysio_arb_if)
//   s   : peripheral slave (master modport of sysio_arb_if)
// Build option: SYSIO_ARB_RR_EN defined -> round-robin per channel;
// undefined -> fixed priority, m0 over m1.
module sysio_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic        clk,
  input logic        rst,
  sysio_arb_if.slave  m0,
  sysio_arb_if.slave  m1,
  sysio_arb_if.master s
);

  typedef enum logic {RIDLE = 1'b0, RBUSY = 1'b1} rstate_e;

  rstate_e state_q, state_d;
  logic    owner_q, owner_d;
  logic    wptr_q, rptr_q;
`ifdef SYSIO_ARB_RR_EN
  logic    wptr_d, rptr_d;
`else
  assign wptr_q = 1'b0;
  assign rptr_q = 1'b0;
`endif

  logic [1:0]             wreq, arreq, rrdy;
  logic [1:0][AW-1:0]     awaddr_m, araddr_m;
  logic [1:0][DW-1:0]     wdata_m;
  logic [1:0][DW/8-1:0]   wstrb_m;
  logic                   wg, rg, wvld, wacc;

  assign wreq      = {m1.axi_awvalid & m1.axi_wvalid, m0.axi_awvalid & m0.axi_wvalid};
  assign arreq     = {m1.axi_arvalid, m0.axi_arvalid};
  assign rrdy      = {m1.axi_rready, m0.axi_rready};
  assign awaddr_m  = {m1.axi_awaddr, m0.axi_awaddr};
  assign wdata_m   = {m1.axi_wdata, m0.axi_wdata};
  assign wstrb_m   = {m1.axi_wstrb, m0.axi_wstrb};
  assign araddr_m  = {m1.axi_araddr, m0.axi_araddr};

  // Pointer only breaks ties; a lone requester always wins.
  assign wg = (&wreq)  ? wptr_q : wreq[1];
  assign rg = (&arreq) ? rptr_q : arreq[1];

  // Write channel: purely combinational pass-through of the winner. Kept
  // apart from the read logic because the slave's awready is a function of
  // our awvalid.
  assign wvld          = ~rst & (|wreq);
  assign s.axi_awvalid = wvld;
  assign s.axi_wvalid  = wvld;
  assign s.axi_awaddr  = wvld ? awaddr_m[wg] : '0;
  assign s.axi_wdata   = wvld ? wdata_m[wg]  : '0;
  assign s.axi_wstrb   = wvld ? wstrb_m[wg]  : '0;
  assign wacc          = wvld & s.axi_awready & s.axi_wready;
  assign m0.axi_awready = wacc & ~wg;
  assign m0.axi_wready  = wacc & ~wg;
  assign m1.axi_awready = wacc & wg;
  assign m1.axi_wready  = wacc & wg;
`ifdef SYSIO_ARB_RR_EN
  assign wptr_d = wacc ? ~wg : wptr_q;
`endif

  // Read channel
  logic                 s_arvalid_o, s_rready_o;
  logic [AW-1:0]        s_araddr_o;
  logic [1:0]           ardy_o, rvalid_o;
  logic [1:0][DW-1:0]   rdata_o;

  always_comb begin
    s_arvalid_o = 1'b0;
    s_araddr_o  = '0;
    s_rready_o  = 1'b0;
    ardy_o      = '0;
    rvalid_o    = '0;
    rdata_o     = '0;
    state_d     = state_q;
    owner_d     = owner_q;
`ifdef SYSIO_ARB_RR_EN
    rptr_d      = rptr_q;
`endif
    // Outputs are forced quiet while reset is held, even with live requests.
    if (!rst) begin
      case (state_q)
        RIDLE: begin
          if (|arreq) begin
            s_arvalid_o = 1'b1;
            s_araddr_o  = araddr_m[rg];
            if (s.axi_arready) begin
              ardy_o[rg] = 1'b1;
              owner_d    = rg;
              state_d    = RBUSY;
`ifdef SYSIO_ARB_RR_EN
              rptr_d     = ~rg;
`endif
            end
          end
        end
        RBUSY: begin
          s_rready_o        = rrdy[owner_q];
          rvalid_o[owner_q] = s.axi_rvalid;
          rdata_o[owner_q]  = s.axi_rdata;
          if (s.axi_rvalid && rrdy[owner_q]) state_d = RIDLE;
        end
        default: state_d = RIDLE;
      endcase
    end
  end

  assign s.axi_arvalid  = s_arvalid_o;
  assign s.axi_araddr   = s_araddr_o;
  assign s.axi_rready   = s_rready_o;
  assign m0.axi_arready = ardy_o[0];
  assign m1.axi_arready = ardy_o[1];
  assign m0.axi_rvalid  = rvalid_o[0];
  assign m1.axi_rvalid  = rvalid_o[1];
  assign m0.axi_rdata   = rdata_o[0];
  assign m1.axi_rdata   = rdata_o[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RIDLE;
      owner_q <= 1'b0;
`ifdef SYSIO_ARB_RR_EN
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef SYSIO_ARB_RR_EN
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sysio_arb.sv
// tb_sysio_arb: randomized + directed scoreboard bench for sysio_arb.
module tb_sysio_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sysio_arb_if #(.AW(32), .DW(32)) m0_if();
  sysio_arb_if #(.AW(32), .DW(32)) m1_if();
  sysio_arb_if #(.AW(32), .DW(32)) s_if();

  sysio_arb #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  // Slave accepts a write whenever address and data are both offered.
  assign s_if.axi_awready = s_if.axi_awvalid & s_if.axi_wvalid;
  assign s_if.axi_wready  = s_if.axi_awvalid & s_if.axi_wvalid;

  int total = 0;
  int bad   = 0;

  // Stimulus for the next cycle
  logic [1:0]  aw, w, ar, rr;
  logic [31:0] awa [2];
  logic [31:0] wd  [2];
  logic [3:0]  ws  [2];
  logic [31:0] ara [2];
  logic        s_ardy;
  int          nxt_dly;
  logic [31:0] nxt_data;

  // Reference model state
  logic        wpref, rpref, rbusy, rown, sl_rv;
  int          sl_cnt;
  logic [31:0] sl_data;

  typedef struct {
    logic       aw_any;
    logic [1:0] awrdy;
    logic       arv;
    logic [1:0] ardy;
    logic       srr;
    logic [1:0] rv;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } lvl_t;
  typedef struct { logic g; logic [31:0] a; logic [31:0] d; logic [3:0] s; } wtx_t;
  typedef struct { logic g; logic [31:0] a; } artx_t;
  typedef struct { logic g; logic [31:0] d; } rtx_t;

  lvl_t  lvl_q [$];
  wtx_t  wq    [$];
  artx_t arq   [$];
  rtx_t  rq    [$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    m0_if.axi_awvalid = aw[0]; m0_if.axi_wvalid = w[0];
    m0_if.axi_awaddr  = awa[0]; m0_if.axi_wdata = wd[0]; m0_if.axi_wstrb = ws[0];
    m0_if.axi_arvalid = ar[0]; m0_if.axi_araddr = ara[0]; m0_if.axi_rready = rr[0];
    m1_if.axi_awvalid = aw[1]; m1_if.axi_wvalid = w[1];
    m1_if.axi_awaddr  = awa[1]; m1_if.axi_wdata = wd[1]; m1_if.axi_wstrb = ws[1];
    m1_if.axi_arvalid = ar[1]; m1_if.axi_araddr = ara[1]; m1_if.axi_rready = rr[1];
    s_if.axi_arready  = s_ardy;
    s_if.axi_rvalid   = sl_rv;
    s_if.axi_rdata    = sl_rv ? sl_data : 32'h0;
  endtask

  task automatic clear_inputs();
    aw = 2'b00; w = 2'b00; ar = 2'b00; rr = 2'b11; s_ardy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      awa[i] = 32'h0; wd[i] = 32'h0; ws[i] = 4'h0; ara[i] = 32'h0;
    end
    nxt_dly = 0; nxt_data = 32'h0;
  endtask

  task automatic model_reset();
    wpref = 1'b0; rpref = 1'b0; rbusy = 1'b0; rown = 1'b0;
    sl_rv = 1'b0; sl_cnt = 0; sl_data = 32'h0;
    lvl_q.delete(); wq.delete(); arq.delete(); rq.delete();
  endtask

  // Apply one cycle of stimulus and record what the arbiter must do with it.
  task automatic step();
    lvl_t  e;
    wtx_t  wt;
    artx_t at;
    rtx_t  rt;
    logic  g;
    @(posedge clk); #1;
    if (rbusy && !sl_rv) begin
      if (sl_cnt == 0) sl_rv = 1'b1;
      else sl_cnt--;
    end
    drive();
    e = '{default: '0};
    // Writes: the slave accepts any offered write the same cycle.
    if ((aw[0] & w[0]) | (aw[1] & w[1])) begin
      if ((aw[0] & w[0]) & (aw[1] & w[1])) g = wpref;
      else g = aw[1] & w[1];
      e.aw_any = 1'b1;
      e.awrdy[g] = 1'b1;
      wt.g = g; wt.a = awa[g]; wt.d = wd[g]; wt.s = ws[g];
      wq.push_back(wt);
`ifdef SYSIO_ARB_RR_EN
      wpref = ~g;
`endif
    end
    // Reads: one outstanding at a time.
    if (!rbusy) begin
      if (ar != 2'b00) begin
        g = (ar == 2'b11) ? rpref : ar[1];
        e.arv = 1'b1;
        e.ardy[g] = s_ardy;
        if (s_ardy) begin
          at.g = g; at.a = ara[g];
          arq.push_back(at);
          rbusy = 1'b1; rown = g;
          sl_cnt = nxt_dly; sl_data = nxt_data;
`ifdef SYSIO_ARB_RR_EN
          rpref = ~g;
`endif
        end
      end
    end else begin
      e.srr = rr[rown];
      e.rv[rown] = sl_rv;
      if (rown) e.rd1 = sl_rv ? sl_data : 32'h0;
      else      e.rd0 = sl_rv ? sl_data : 32'h0;
      if (sl_rv && rr[rown]) begin
        rt.g = rown; rt.d = sl_data;
        rq.push_back(rt);
        rbusy = 1'b0;
        sl_rv = 1'b0;
      end
    end
    lvl_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_s_awvalid"}, s_if.axi_awvalid, 1'b0);
    chk1({tag, "_s_wvalid"},  s_if.axi_wvalid,  1'b0);
    chk1({tag, "_s_arvalid"}, s_if.axi_arvalid, 1'b0);
    chk1({tag, "_s_rready"},  s_if.axi_rready,  1'b0);
    chk32({tag, "_s_awaddr"}, s_if.axi_awaddr, 32'h0);
    chk32({tag, "_s_wdata"},  s_if.axi_wdata,  32'h0);
    chk32({tag, "_s_araddr"}, s_if.axi_araddr, 32'h0);
    chk1({tag, "_m0_awready"}, m0_if.axi_awready, 1'b0);
    chk1({tag, "_m1_awready"}, m1_if.axi_awready, 1'b0);
    chk1({tag, "_m0_arready"}, m0_if.axi_arready, 1'b0);
    chk1({tag, "_m1_arready"}, m1_if.axi_arready, 1'b0);
    chk1({tag, "_m0_rvalid"},  m0_if.axi_rvalid,  1'b0);
    chk1({tag, "_m1_rvalid"},  m1_if.axi_rvalid,  1'b0);
    chk32({tag, "_m0_rdata"},  m0_if.axi_rdata,  32'h0);
    chk32({tag, "_m1_rdata"},  m1_if.axi_rdata,  32'h0);
  endtask

  // Monitor: compares per-cycle levels and pops transactions as the DUT
  // presents them.
  always @(negedge clk) begin
    lvl_t  e;
    wtx_t  wt;
    artx_t at;
    rtx_t  rt;
    if (!rst) begin
      if (lvl_q.size() > 0) begin
        e = lvl_q.pop_front();
        chk1("s_awvalid", s_if.axi_awvalid, e.aw_any);
        chk1("s_wvalid",  s_if.axi_wvalid,  e.aw_any);
        chk1("m0_awready", m0_if.axi_awready, e.awrdy[0]);
        chk1("m0_wready",  m0_if.axi_wready,  e.awrdy[0]);
        chk1("m1_awready", m1_if.axi_awready, e.awrdy[1]);
        chk1("m1_wready",  m1_if.axi_wready,  e.awrdy[1]);
        if (!e.aw_any) chk32("idle_awaddr", s_if.axi_awaddr, 32'h0);
        chk1("s_arvalid",  s_if.axi_arvalid, e.arv);
        chk1("m0_arready", m0_if.axi_arready, e.ardy[0]);
        chk1("m1_arready", m1_if.axi_arready, e.ardy[1]);
        if (!e.arv) chk32("idle_araddr", s_if.axi_araddr, 32'h0);
        chk1("s_rready",  s_if.axi_rready, e.srr);
        chk1("m0_rvalid", m0_if.axi_rvalid, e.rv[0]);
        chk1("m1_rvalid", m1_if.axi_rvalid, e.rv[1]);
        chk32("m0_rdata", m0_if.axi_rdata, e.rd0);
        chk32("m1_rdata", m1_if.axi_rdata, e.rd1);
      end
      if (s_if.axi_awvalid) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL w_unexpected got=write want=none t=%0t", $time);
        end else begin
          wt = wq.pop_front();
          chk32("w_addr", s_if.axi_awaddr, wt.a);
          chk32("w_data", s_if.axi_wdata, wt.d);
          chk32("w_strb", {28'h0, s_if.axi_wstrb}, {28'h0, wt.s});
        end
      end
      if (s_if.axi_arvalid && s_if.axi_arready) begin
        if (arq.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected got=read want=none t=%0t", $time);
        end else begin
          at = arq.pop_front();
          chk32("ar_addr", s_if.axi_araddr, at.a);
          chk1("ar_grant_m1", m1_if.axi_arready, at.g);
        end
      end
      if ((m0_if.axi_rvalid && m0_if.axi_rready) || (m1_if.axi_rvalid && m1_if.axi_rready)) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected got=resp want=none t=%0t", $time);
        end else begin
          rt = rq.pop_front();
          chk1("r_owner_m1", m1_if.axi_rvalid, rt.g);
          chk32("r_data", rt.g ? m1_if.axi_rdata : m0_if.axi_rdata, rt.d);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    model_reset();
    // Requests present while reset is held must not leak to any output.
    aw = 2'b11; w = 2'b11; ar = 2'b11; awa[0] = 32'h0000_0400; ara[0] = 32'h0000_0400;
    drive();
    #2;
    chk_all_zero("rst0");
    clear_inputs();
    drive();
    @(posedge clk); #2 rst = 1'b0;

    // Both masters hold writes for 8 cycles.
    aw = 2'b11; w = 2'b11;
    awa[0] = 32'h0000_0400; awa[1] = 32'h0000_0404;
    wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0000; ws[0] = 4'hF; ws[1] = 4'h3;
    repeat (8) step();
    clear_inputs();

    // Read blocking: m0 owns the read, m1 waits with arvalid held.
    ar = 2'b11; ara[0] = 32'h0000_0400; ara[1] = 32'h0000_0F00;
    nxt_dly = 1; nxt_data = 32'hA5A5_0001;
    step();
    ar = 2'b10; nxt_dly = 0; nxt_data = 32'h0F00_D00D;
    repeat (3) step();
    ar = 2'b00;
    repeat (2) step();

    // Backpressure: m0 holds rready low for 3 cycles of rvalid.
    ar = 2'b01; ara[0] = 32'h0000_0408; nxt_dly = 0; nxt_data = 32'h1234_5678;
    rr = 2'b10;
    step();
    ar = 2'b00;
    repeat (3) step();
    rr = 2'b11;
    repeat (2) step();

    // Concurrent m0 write and m1 read.
    aw = 2'b01; w = 2'b01; awa[0] = 32'h0000_0408; wd[0] = 32'hCAFE_0408; ws[0] = 4'hF;
    ar = 2'b10; ara[1] = 32'h0000_0400; nxt_dly = 0; nxt_data = 32'h0BAD_0400;
    step();
    clear_inputs();
    repeat (3) step();

    // Reset while a read is in flight and a write is being offered.
    ar = 2'b01; ara[0] = 32'h0000_040C; rr = 2'b10; nxt_dly = 0; nxt_data = 32'h7777_0001;
    step();
    ar = 2'b00; aw = 2'b10; w = 2'b10; awa[1] = 32'h0000_0500; wd[1] = 32'h5;
    step();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    clear_inputs();
    model_reset();
    drive();
    @(posedge clk); #2 rst = 1'b0;
    ar = 2'b10; ara[1] = 32'h0000_0404; nxt_dly = 0; nxt_data = 32'h0404_BEEF;
    step();
    ar = 2'b00;
    repeat (3) step();

    // Randomized traffic.
    repeat (3000) begin
      aw = 2'($urandom);
      w  = aw ^ ((($urandom % 4) == 0) ? 2'($urandom) : 2'b00);
      ar = 2'($urandom);
      rr = 2'($urandom) | 2'($urandom);
      s_ardy = ($urandom % 4) != 0;
      for (int i = 0; i < 2; i++) begin
        awa[i] = $urandom; wd[i] = $urandom; ws[i] = 4'($urandom); ara[i] = $urandom;
      end
      nxt_dly = $urandom_range(0, 3);
      nxt_data = $urandom;
      step();
    end
    clear_inputs();
    repeat (8) step();

    @(negedge clk); #1;
    chk32("lvl_left", 32'(lvl_q.size()), 32'h0);
    chk32("wq_left",  32'(wq.size()), 32'h0);
    chk32("arq_left", 32'(arq.size()), 32'h0);
    chk32("rq_left",  32'(rq.size()), 32'h0);
    chk1("model_idle", rbusy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
